// File: rtl/front_panel_pkg.sv
// Shared encodings for the front-panel input stage.
//   run_state_t : core run/pause/step/halted state, also driven onto run_state
//   BTN_*       : bit position of each push button in Switch / btn_level / btn_press
//   VIEW_*      : register selection shown on the LEDs
package front_panel_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE  = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } run_state_t;

   localparam int BTN_RUN   = 0;
   localparam int BTN_RST   = 1;
   localparam int BTN_STEP  = 2;
   localparam int BTN_VIEW1 = 3;
   localparam int BTN_VIEW2 = 4;
   localparam int BTN_VIEW3 = 5;

   localparam logic [1:0] VIEW_MEM = 2'd0;
   localparam logic [1:0] VIEW_A   = 2'd1;
   localparam logic [1:0] VIEW_B   = 2'd2;
   localparam logic [1:0] VIEW_C   = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: two-flop synchroniser, stable-level debounce
// and a one-cycle pulse on the debounced press edge.
//   CLK_12MHz  : system clock
//   RST_n      : synchronous active-low reset
//   switch_raw : raw button, 0 = pressed
//   level      : debounced level, 1 = pressed
//   press      : one-cycle pulse in the cycle after level rises
module btn_debounce
   import front_panel_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int CNT_W           = 17
) (
   input  logic CLK_12MHz,
   input  logic RST_n,
   input  logic switch_raw,
   output logic level,
   output logic press
);

   logic             sync_1;
   logic             sync_2;
   logic             level_d;
   logic             pressed_sync;
   logic [CNT_W-1:0] cnt;

   // Inversion after the second flop: synchroniser runs in raw polarity so a
   // reset preset of 1 means "released".
   assign pressed_sync = ~sync_2;

   always_ff @(posedge CLK_12MHz) begin
      if (!RST_n) begin
         sync_1  <= 1'b1;
         sync_2  <= 1'b1;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= switch_raw;
         sync_2  <= sync_1;
         level_d <= level;
         press   <= level & ~level_d;
         if (pressed_sync == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level <= pressed_sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/front_panel_ctrl.sv
// Front-panel controller for the 8-bit core: debounces the six buttons and
// turns them into run/pause, single-step, core reset and LED view select.
//   CLK_12MHz : system clock          RST_n     : sync active-low reset
//   Switch    : raw buttons, 0=press  halt_i    : core fetched HALT
//   cpu_en    : core advance strobe   cpu_rst   : core reset pulse
//   btn_level : debounced levels      btn_press : debounced press pulses
//   run_state : run_state_t           view_sel  : LED register select
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_PAUSE  | core idle, waiting for run or step
// ST_RUN    | free-running, cpu_en every TICK_DIV cycles, watching halt_i
// ST_STEP   | issue exactly one cpu_en, then back to PAUSE
// ST_HALTED | core hit HALT; only the reset button leaves this state
module front_panel_ctrl
   import front_panel_pkg::*;
#(
   parameter int NUM_BTN         = 6,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int CNT_W           = 17,
   parameter int TICK_DIV        = 2048
) (
   input  logic               CLK_12MHz,
   input  logic               RST_n,
   input  logic [NUM_BTN-1:0] Switch,
   input  logic               halt_i,
   output logic               cpu_en,
   output logic               cpu_rst,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [1:0]         run_state,
   output logic [1:0]         view_sel
);

   localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   run_state_t        state;
   logic [TICK_W-1:0] tick;

   assign run_state = state;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .CLK_12MHz  (CLK_12MHz),
         .RST_n      (RST_n),
         .switch_raw (Switch[i]),
         .level      (btn_level[i]),
         .press      (btn_press[i])
      );
   end

   always_ff @(posedge CLK_12MHz) begin
      if (!RST_n) begin
         state    <= ST_PAUSE;
         tick     <= '0;
         cpu_en   <= 1'b0;
         cpu_rst  <= 1'b0;
         view_sel <= VIEW_MEM;
      end else begin
         cpu_en  <= 1'b0;
         cpu_rst <= 1'b0;

         if (btn_press[BTN_RST]) begin
            cpu_rst <= 1'b1;
            state   <= ST_PAUSE;
            tick    <= '0;
         end else begin
            case (state)
               ST_PAUSE: begin
                  tick <= '0;
                  if (btn_press[BTN_RUN])       state <= ST_RUN;
                  else if (btn_press[BTN_STEP]) state <= ST_STEP;
               end
               ST_RUN: begin
                  if (halt_i) begin
                     state <= ST_HALTED;
                     tick  <= '0;
                  end else if (btn_press[BTN_RUN]) begin
                     state <= ST_PAUSE;
                     tick  <= '0;
                  end else begin
                     // cpu_en is registered, so it is armed one count early to
                     // line up with tick == TICK_DIV-1.
                     cpu_en <= (tick == TICK_W'(TICK_DIV - 2));
                     if (tick == TICK_W'(TICK_DIV - 1)) tick <= '0;
                     else                               tick <= tick + TICK_W'(1);
                  end
               end
               ST_STEP: begin
                  tick   <= '0;
                  cpu_en <= 1'b1;
                  state  <= ST_PAUSE;
               end
               ST_HALTED: begin
                  tick <= '0;
               end
               default: begin
                  state <= ST_PAUSE;
                  tick  <= '0;
               end
            endcase
         end

         if (btn_press[BTN_RST])        view_sel <= VIEW_MEM;
         else if (btn_press[BTN_VIEW3]) view_sel <= VIEW_C;
         else if (btn_press[BTN_VIEW2]) view_sel <= VIEW_B;
         else if (btn_press[BTN_VIEW1]) view_sel <= VIEW_A;
      end
   end

endmodule

// File: tb/tb_front_panel_ctrl.sv
module tb_front_panel_ctrl;

   logic       CLK_12MHz = 1'b0;
   logic       RST_n     = 1'b0;
   logic [5:0] Switch    = 6'b111111;
   logic       halt_i    = 1'b0;
   logic       cpu_en;
   logic       cpu_rst;
   logic [5:0] btn_level;
   logic [5:0] btn_press;
   logic [1:0] run_state;
   logic [1:0] view_sel;

   int checks   = 0;
   int failures = 0;
   int en_count = 0;
   int rst_count = 0;
   int step_seen = 0;

   front_panel_ctrl #(
      .NUM_BTN         (6),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3),
      .TICK_DIV        (8)
   ) dut (
      .CLK_12MHz (CLK_12MHz),
      .RST_n     (RST_n),
      .Switch    (Switch),
      .halt_i    (halt_i),
      .cpu_en    (cpu_en),
      .cpu_rst   (cpu_rst),
      .btn_level (btn_level),
      .btn_press (btn_press),
      .run_state (run_state),
      .view_sel  (view_sel)
   );

   always #5 CLK_12MHz = ~CLK_12MHz;

   task automatic cycle_mon();
      @(negedge CLK_12MHz);
      if (cpu_en === 1'b1) en_count++;
      if (cpu_rst === 1'b1) rst_count++;
      if (run_state === 2'd2) step_seen++;
   endtask

   // Hold the buttons in mask pressed long enough to debounce, then release
   // and wait for the release to settle.
   task automatic press_btn(input logic [5:0] mask);
      Switch = ~mask;
      repeat (8) cycle_mon();
      Switch = 6'b111111;
      repeat (8) cycle_mon();
   endtask

   task automatic test_reset();
      int bad;
      RST_n  = 1'b0;
      Switch = 6'b111111;
      halt_i = 1'b0;
      repeat (3) @(negedge CLK_12MHz);
      checks++;
      if ({cpu_en, cpu_rst, btn_level, btn_press, run_state, view_sel} !== 18'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {cpu_en, cpu_rst, btn_level, btn_press, run_state, view_sel});
      end
      RST_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK_12MHz);
         if (btn_press !== 6'd0 || cpu_en !== 1'b0 || run_state !== 2'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_exit_quiet: got %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_glitch();
      int bad;
      Switch[0] = 1'b0;
      repeat (3) @(negedge CLK_12MHz);
      Switch[0] = 1'b1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK_12MHz);
         if (btn_level !== 6'd0 || btn_press !== 6'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL glitch_reject: got %0d bad cycles required 0", bad);
      end
   endtask

   task automatic test_debounce();
      int lvl_at, prs_first, prs_cnt;
      lvl_at = -1; prs_first = -1; prs_cnt = 0;
      Switch[0] = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge CLK_12MHz);
         if (btn_level[0] === 1'b1 && lvl_at < 0) lvl_at = c;
         if (btn_press[0] === 1'b1) begin
            prs_cnt++;
            if (prs_first < 0) prs_first = c;
         end
         if (c == 10) Switch[0] = 1'b1;
      end
      checks++;
      if (lvl_at != 6) begin
         failures++;
         $display("FAIL level_latency: got %0d required 6", lvl_at);
      end
      checks++;
      if (prs_first != 7) begin
         failures++;
         $display("FAIL press_timing: got %0d required 7", prs_first);
      end
      checks++;
      if (prs_cnt != 1) begin
         failures++;
         $display("FAIL press_count: got %0d required 1", prs_cnt);
      end
      checks++;
      if (btn_level !== 6'd0) begin
         failures++;
         $display("FAIL release_level: got %b required 000000", btn_level);
      end
      checks++;
      if (run_state !== 2'd1) begin
         failures++;
         $display("FAIL enter_run: got %0d required 1", run_state);
      end
   endtask

   task automatic test_run_tick();
      int cnt, last, bad_gap;
      cnt = 0; last = -1; bad_gap = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK_12MHz);
         if (cpu_en === 1'b1) begin
            if (last >= 0 && (c - last) != 8) bad_gap++;
            last = c;
            cnt++;
         end
      end
      checks++;
      if (cnt != 5) begin
         failures++;
         $display("FAIL tick_count: got %0d required 5", cnt);
      end
      checks++;
      if (bad_gap != 0) begin
         failures++;
         $display("FAIL tick_spacing: got %0d bad gaps required 0", bad_gap);
      end
      press_btn(6'b000001);
      checks++;
      if (run_state !== 2'd0) begin
         failures++;
         $display("FAIL run_to_pause: got %0d required 0", run_state);
      end
      en_count = 0;
      repeat (20) cycle_mon();
      checks++;
      if (en_count != 0) begin
         failures++;
         $display("FAIL pause_no_en: got %0d strobes required 0", en_count);
      end
   endtask

   task automatic test_step();
      en_count = 0;
      step_seen = 0;
      press_btn(6'b000100);
      checks++;
      if (run_state !== 2'd0 || step_seen != 1) begin
         failures++;
         $display("FAIL step_one: got state %0d step cycles %0d required 0 and 1",
                  run_state, step_seen);
      end
      press_btn(6'b000100);
      checks++;
      if (step_seen != 2) begin
         failures++;
         $display("FAIL step_two: got step cycles %0d required 2", step_seen);
      end
      checks++;
      if (en_count != 2) begin
         failures++;
         $display("FAIL step_en_count: got %0d required 2", en_count);
      end
   endtask

   task automatic test_halt();
      press_btn(6'b010000);
      checks++;
      if (view_sel !== 2'd2) begin
         failures++;
         $display("FAIL view_b: got %0d required 2", view_sel);
      end
      press_btn(6'b000001);
      checks++;
      if (run_state !== 2'd1) begin
         failures++;
         $display("FAIL rerun: got %0d required 1", run_state);
      end
      halt_i = 1'b1;
      @(negedge CLK_12MHz);
      checks++;
      if (run_state !== 2'd3) begin
         failures++;
         $display("FAIL halt_enter: got %0d required 3", run_state);
      end
      en_count = 0;
      press_btn(6'b000001);
      press_btn(6'b000100);
      checks++;
      if (run_state !== 2'd3 || en_count != 0) begin
         failures++;
         $display("FAIL halt_ignore: got state %0d strobes %0d required 3 and 0",
                  run_state, en_count);
      end
      rst_count = 0;
      press_btn(6'b000010);
      checks++;
      if (rst_count != 1) begin
         failures++;
         $display("FAIL halt_cpu_rst: got %0d pulses required 1", rst_count);
      end
      checks++;
      if (run_state !== 2'd0 || view_sel !== 2'd0) begin
         failures++;
         $display("FAIL halt_reset_exit: got state %0d view %0d required 0 and 0",
                  run_state, view_sel);
      end
      halt_i = 1'b0;
   endtask

   task automatic test_view();
      press_btn(6'b001000);
      checks++;
      if (view_sel !== 2'd1) begin
         failures++;
         $display("FAIL view_a: got %0d required 1", view_sel);
      end
      press_btn(6'b101000);
      checks++;
      if (view_sel !== 2'd3) begin
         failures++;
         $display("FAIL view_priority: got %0d required 3", view_sel);
      end
      rst_count = 0;
      press_btn(6'b010010);
      checks++;
      if (view_sel !== 2'd0 || rst_count != 1 || run_state !== 2'd0) begin
         failures++;
         $display("FAIL view_rst_override: got view %0d rst %0d state %0d required 0 1 0",
                  view_sel, rst_count, run_state);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_debounce();
      test_run_tick();
      test_step();
      test_halt();
      test_view();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
